// File: rtl/pipes_pkg.sv
`default_nettype none
// ============================================================================
// pipes_pkg : shared pipeline types and the PC redirect state encoding.
// Rev 1.0
// ============================================================================
package pipes_pkg;

   typedef logic        u1;
   typedef logic [63:0] u64;

   typedef enum logic [0:0] {
      RS_IDLE = 1'b0,
      RS_WAIT = 1'b1
   } redirect_state_t;

   localparam u64 c_pend_pc_reset = 64'h0;

endpackage : pipes_pkg
`default_nettype wire

// File: rtl/pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// pc_redirect_ctrl : arbitrates decode/commit PC redirects against an
// outstanding instruction fetch, holding the redirect until the fetch resolves.
// Rev 1.0
// ============================================================================
module pc_redirect_ctrl
   import pipes_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  u1                 clk,
   input  u1                 reset,
   input  u1                 d_redirect,
   input  u64                d_target,
   input  u1                 d_valid,
   input  u1                 stall_d,
   input  u1                 c_redirect,
   input  u64                c_target,
   input  u1                 i_busy,
   input  u1                 i_data_ok,
   output u1                 pc_sel,
   output u64                pc_next,
   output u1                 flush_f,
   output u1                 flush_d,
   output u1                 drop_f,
   output u1                 pending,
   output logic [CNT_W-1:0]  d_cnt,
   output logic [CNT_W-1:0]  c_cnt
);

   redirect_state_t r_state;
   u64              r_pend_pc;
   logic [CNT_W-1:0] r_d_cnt;
   logic [CNT_W-1:0] r_c_cnt;

   redirect_state_t w_state_nxt;
   u64              w_pend_nxt;
   u64              w_tgt;
   u64              w_redir;
   u1               w_c_acc;
   u1               w_d_acc;

   // Commit always wins; decode is only taken from IDLE and never alongside a commit.
   always_comb begin
      w_c_acc = c_redirect & ~reset;
      w_d_acc = d_redirect & d_valid & ~stall_d & ~c_redirect & ~reset
                & (r_state == RS_IDLE);
      w_tgt   = c_redirect ? c_target : d_target;
      w_redir = w_c_acc ? c_target : r_pend_pc;

      pc_sel      = 1'b0;
      pc_next     = 64'h0;
      flush_f     = 1'b0;
      flush_d     = 1'b0;
      drop_f      = 1'b0;
      w_state_nxt = r_state;
      w_pend_nxt  = r_pend_pc;

      case (r_state)
         RS_IDLE: begin
            if (w_c_acc | w_d_acc) begin
               flush_f = 1'b1;
               flush_d = w_c_acc;
               if (i_busy & ~i_data_ok) begin
                  w_state_nxt = RS_WAIT;
                  w_pend_nxt  = w_tgt;
               end else begin
                  pc_sel  = 1'b1;
                  pc_next = w_tgt;
                  drop_f  = i_busy;
               end
            end
         end
         RS_WAIT: begin
            flush_f = 1'b1;
            flush_d = w_c_acc;
            if (i_busy & ~i_data_ok) begin
               w_pend_nxt = w_redir;
            end else begin
               // Fetch either returned (drop it) or was aborted; both release the held PC.
               pc_sel      = 1'b1;
               pc_next     = w_redir;
               drop_f      = i_busy;
               w_state_nxt = RS_IDLE;
            end
         end
         default: begin
            w_state_nxt = RS_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= RS_IDLE;
         r_pend_pc <= c_pend_pc_reset;
         r_d_cnt   <= '0;
         r_c_cnt   <= '0;
      end else begin
         r_state   <= w_state_nxt;
         r_pend_pc <= w_pend_nxt;
         r_d_cnt   <= r_d_cnt + {{(CNT_W-1){1'b0}}, w_d_acc};
         r_c_cnt   <= r_c_cnt + {{(CNT_W-1){1'b0}}, w_c_acc};
      end
   end

   assign pending = (r_state == RS_WAIT);
   assign d_cnt   = r_d_cnt;
   assign c_cnt   = r_c_cnt;

endmodule : pc_redirect_ctrl
`default_nettype wire

// File: tb/tb_pc_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pc_redirect_ctrl : directed bench with a behavioural redirect model.
// Rev 1.0
// ============================================================================
module tb_pc_redirect_ctrl;

   localparam int CNT_W = 16;
   localparam int unsigned c_mod = 1 << CNT_W;

   logic              clk = 1'b0;
   logic              reset;
   logic              d_redirect, d_valid, stall_d, c_redirect, i_busy, i_data_ok;
   logic [63:0]       d_target, c_target;
   logic              pc_sel, flush_f, flush_d, drop_f, pending;
   logic [63:0]       pc_next;
   logic [CNT_W-1:0]  d_cnt, c_cnt;

   int n_tests = 0;
   int n_fail  = 0;

   // model state (current and next)
   bit          m_wait, n_wait;
   logic [63:0] m_pend, n_pend;
   int unsigned m_dc, m_cc, n_dc, n_cc;

   always #5 clk = ~clk;

   pc_redirect_ctrl #(.CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset),
      .d_redirect(d_redirect), .d_target(d_target), .d_valid(d_valid), .stall_d(stall_d),
      .c_redirect(c_redirect), .c_target(c_target),
      .i_busy(i_busy), .i_data_ok(i_data_ok),
      .pc_sel(pc_sel), .pc_next(pc_next), .flush_f(flush_f), .flush_d(flush_d),
      .drop_f(drop_f), .pending(pending), .d_cnt(d_cnt), .c_cnt(c_cnt)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Expected outputs for the current cycle, from the redirect rules.
   task automatic check_model();
      bit          take_c, take_d, e_sel, e_ff, e_fd, e_drop;
      logic [63:0] e_next, dest;
      e_sel = 0; e_ff = 0; e_fd = 0; e_drop = 0; e_next = 64'h0;
      if (reset) begin
         m_wait = 0; m_pend = 0; m_dc = 0; m_cc = 0;
         n_wait = 0; n_pend = 0; n_dc = 0; n_cc = 0;
      end else begin
         take_c = c_redirect;
         take_d = !m_wait && d_redirect && d_valid && !stall_d && !c_redirect;
         n_wait = m_wait;
         n_pend = m_pend;
         n_dc   = take_d ? (m_dc + 1) % c_mod : m_dc;
         n_cc   = take_c ? (m_cc + 1) % c_mod : m_cc;
         if (!m_wait) begin
            dest = take_c ? c_target : d_target;
            if (take_c || take_d) begin
               e_ff = 1;
               e_fd = take_c;
               if (!i_busy) begin
                  e_sel = 1; e_next = dest;
               end else if (i_data_ok) begin
                  e_sel = 1; e_next = dest; e_drop = 1;
               end else begin
                  n_wait = 1; n_pend = dest;
               end
            end
         end else begin
            dest = take_c ? c_target : m_pend;
            e_ff = 1;
            e_fd = take_c;
            if (!i_busy) begin
               e_sel = 1; e_next = dest; n_wait = 0;
            end else if (i_data_ok) begin
               e_sel = 1; e_next = dest; e_drop = 1; n_wait = 0;
            end else begin
               n_pend = dest;
            end
         end
      end
      chk("pending", {63'h0, pending}, {63'h0, m_wait});
      chk("d_cnt", {{(64-CNT_W){1'b0}}, d_cnt}, 64'(m_dc));
      chk("c_cnt", {{(64-CNT_W){1'b0}}, c_cnt}, 64'(m_cc));
      chk("pc_sel", {63'h0, pc_sel}, {63'h0, e_sel});
      chk("flush_f", {63'h0, flush_f}, {63'h0, e_ff});
      chk("flush_d", {63'h0, flush_d}, {63'h0, e_fd});
      chk("drop_f", {63'h0, drop_f}, {63'h0, e_drop});
      if (e_sel) chk("pc_next", pc_next, e_next);
   endtask

   task automatic step(input logic dr, input logic [63:0] dt, input logic dv, input logic sd,
                       input logic cr, input logic [63:0] ct, input logic ib, input logic ok);
      d_redirect = dr; d_target = dt; d_valid = dv; stall_d = sd;
      c_redirect = cr; c_target = ct; i_busy = ib; i_data_ok = ok;
      #3;
      check_model();
   endtask

   task automatic tick();
      @(posedge clk);
      if (!reset) begin
         m_wait = n_wait; m_pend = n_pend; m_dc = n_dc; m_cc = n_cc;
      end
      #1;
   endtask

   task automatic idle(input logic ib, input logic ok);
      step(0, 64'h0, 1, 0, 0, 64'h0, ib, ok);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      idle(0, 0);
      tick();
      reset = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      d_redirect = 0; d_target = 0; d_valid = 0; stall_d = 0;
      c_redirect = 0; c_target = 0; i_busy = 0; i_data_ok = 0;
      m_wait = 0; m_pend = 0; m_dc = 0; m_cc = 0;
      n_wait = 0; n_pend = 0; n_dc = 0; n_cc = 0;
      #1;
      do_reset();
      chk("reset_pc_sel", {63'h0, pc_sel}, 64'h0);
      chk("reset_pending", {63'h0, pending}, 64'h0);

      // decode redirect, fetch idle: same-cycle apply
      step(1, 64'h8000_0040, 1, 0, 0, 64'h0, 0, 0);
      chk("r37_pc_sel", {63'h0, pc_sel}, 64'h1);
      chk("r37_pc_next", pc_next, 64'h8000_0040);
      chk("r37_flush_f", {63'h0, flush_f}, 64'h1);
      tick();
      idle(0, 0);
      chk("r37_d_cnt", {48'h0, d_cnt}, 64'h1);
      tick();

      // decode redirect while fetch busy, returns three cycles later
      step(1, 64'h8000_0100, 1, 0, 0, 64'h0, 1, 0);
      chk("r38_no_sel", {63'h0, pc_sel}, 64'h0);
      tick();
      for (int i = 0; i < 2; i++) begin
         idle(1, 0);
         chk("r38_pending", {63'h0, pending}, 64'h1);
         chk("r38_flush_f", {63'h0, flush_f}, 64'h1);
         tick();
      end
      idle(1, 1);
      chk("r38_pending_ok", {63'h0, pending}, 64'h1);
      chk("r38_drop_f", {63'h0, drop_f}, 64'h1);
      chk("r38_pc_next", pc_next, 64'h8000_0100);
      tick();
      idle(0, 0);
      chk("r38_released", {63'h0, pending}, 64'h0);
      tick();

      // simultaneous decode and commit
      do_reset();
      step(1, 64'h100, 1, 0, 1, 64'h200, 0, 0);
      chk("r39_pc_next", pc_next, 64'h200);
      chk("r39_flush_d", {63'h0, flush_d}, 64'h1);
      tick();
      idle(0, 0);
      chk("r39_c_cnt", {48'h0, c_cnt}, 64'h1);
      chk("r39_d_cnt", {48'h0, d_cnt}, 64'h0);
      tick();

      // commit overrides a held decode redirect; decode in WAIT ignored
      step(1, 64'h100, 1, 0, 0, 64'h0, 1, 0); tick();
      step(0, 64'h0, 1, 0, 1, 64'h300, 1, 0); tick();
      step(1, 64'h500, 1, 0, 0, 64'h0, 1, 0); tick();
      idle(1, 1);
      chk("r40_pc_next", pc_next, 64'h300);
      tick();
      idle(0, 0);
      chk("r40_d_cnt", {48'h0, d_cnt}, 64'h1);
      tick();

      // commit arriving in the same cycle as the fetch return
      step(1, 64'h700, 1, 0, 0, 64'h0, 1, 0); tick();
      step(0, 64'h0, 1, 0, 1, 64'h900, 1, 1);
      chk("wait_ok_commit", pc_next, 64'h900);
      tick();

      // fetch aborted while waiting; then stalled / invalid decode not taken
      step(1, 64'h1234, 1, 0, 0, 64'h0, 1, 0); tick();
      idle(0, 0);
      chk("abort_pc_next", pc_next, 64'h1234);
      tick();
      step(1, 64'h40, 1, 1, 0, 64'h0, 0, 0); tick();
      step(1, 64'h40, 0, 0, 0, 64'h0, 0, 0); tick();
      // IDLE accept with fetch returning in the same cycle
      step(1, 64'hFFFF_FFFF_FFFF_FFFE, 1, 0, 0, 64'h0, 1, 1);
      chk("idle_ok_drop", {63'h0, drop_f}, 64'h1);
      tick();

      // reset pulse in WAIT discards the held redirect
      step(1, 64'h100, 1, 0, 0, 64'h0, 1, 0); tick();
      idle(1, 0);
      reset = 1'b1;
      idle(1, 0);
      tick();
      reset = 1'b0;
      idle(1, 1);
      chk("r42_pc_sel", {63'h0, pc_sel}, 64'h0);
      chk("r42_pending", {63'h0, pending}, 64'h0);
      chk("r42_c_cnt", {48'h0, c_cnt}, 64'h0);
      tick();

      // decode counter wrap
      do_reset();
      for (int i = 0; i < 65535; i++) begin
         step(1, 64'(i), 1, 0, 0, 64'h0, 0, 0);
         tick();
      end
      idle(0, 0);
      chk("r41_full", {48'h0, d_cnt}, 64'hFFFF);
      step(1, 64'h8, 1, 0, 0, 64'h0, 0, 0);
      tick();
      idle(0, 0);
      chk("r41_wrap", {48'h0, d_cnt}, 64'h0);
      tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule : tb_pc_redirect_ctrl
`default_nettype wire
